path_recorder: RTL and testbench
================================

Name: path_recorder

Overview:
- Sits directly downstream of the maze solver and records its search as a direction stack.
  - Forward step: push.
  - Backtrack: pop.
- When the solver reports done, the recorded stack is the start-to-goal path.
- On `run`, the block replays that path one direction per handshake to the display/consumer stage.
- On solver fail, the block reports an empty path.

Parameters:
- DEPTH, 256, maximum number of stored moves (power of two).
- AW, 8, log2(DEPTH); pointer width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous restart. Pulsed with solver start. Empties the stack and enters RECORD.
- push  input  1  solver moved forward; store dir_in.
- pop  input  1  solver backtracked; discard top entry.
- dir_in  input  2  direction of the forward move: 0=up, 1=right, 2=down, 3=left.
- solve_done  input  1  solver reached goal (1-cycle pulse).
- solve_fail  input  1  solver exhausted maze (1-cycle pulse).
- run  input  1  request replay (level or pulse; sampled in READY only).
- out_valid  output  1  dir_out holds a valid path element.
- out_ready  input  1  consumer accepts the element.
- dir_out  output  2  current replayed direction.
- last  output  1  high with out_valid on the final element.
- path_len  output  AW+1  number of stored moves; live in RECORD, frozen afterwards.
- busy  output  1  high in REPLAY.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - State is RECORD; sp=0; rd=0.
  - All outputs are 0: out_valid, dir_out, last, path_len, busy, overflow, underflow.
  - Memory contents are don't-care.
- States: RECORD, READY, REPLAY, FAIL.
- clear (any state) → RECORD next cycle:
  - sp=0, rd=0, overflow=0, underflow=0, out_valid=0.
  - clear has priority over all other inputs.
- RECORD, per cycle:
  - push only: mem[sp]←dir_in, sp+1. If sp==DEPTH, the write is ignored and overflow←1.
  - pop only: sp−1. If sp==0, it is ignored and underflow←1.
  - push and pop together: replace the top, mem[sp−1]←dir_in, sp unchanged. If sp==0, treat as push only.
  - solve_done → READY; push/pop in that same cycle are applied first.
  - solve_fail → FAIL; sp←0.
  - solve_done and solve_fail together: solve_fail wins.
- READY:
  - push, pop, solve_* are ignored.
  - run=1 with sp>0 → REPLAY, rd←0.
  - run=1 with sp==0 → stays in READY; no output.
- REPLAY:
  - out_valid=1 from the cycle after run is sampled; latency is 1 clock.
  - dir_out=mem[rd]; last=(rd==sp−1); busy=1.
  - On out_valid&out_ready: rd+1. If last, → READY next cycle with out_valid=0.
  - While out_ready=0: dir_out and last are held stable and out_valid stays 1.
- FAIL:
  - path_len=0; run is ignored; only clear or rst leaves the state.
- path_len:
  - In RECORD it mirrors sp, registered, including updates made in the same cycle.
  - In READY, REPLAY and FAIL it is frozen.
- Replay is repeatable: each run from READY restarts at rd=0.
- Storage: register array; combinational read of mem[rd] feeding the output.

Optional Feature:
- Macro: PATH_COORD_EN.
- Defined:
  - Adds outputs pos_x[3:0] and pos_y[3:0].
  - Both reset to 0 and are cleared to 0 on clear and on entry to REPLAY.
  - They are valid with out_valid and show the cell reached after applying dir_out:
    - up: y−1
    - right: x+1
    - down: y+1
    - left: x−1
  - Arithmetic wraps modulo 16.
  - The running position is committed on each accepted handshake.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset then clear; push dirs 1,1,2,3; solve_done; run with out_ready=1.
  → dir_out 1,1,2,3 on 4 consecutive cycles; last only on the 4th; path_len=4; back to READY.
- Push 1,2; pop; push 2 with pop in the same cycle; push 1; solve_done; replay.
  → sequence 2,1; path_len=2.
- Record 3 moves, replay with out_ready toggling 0,1,0,1….
  → each element held until accepted; 3 handshakes total; busy low after the final one.
- Pop at sp=0 → underflow=1, sp=0.
- Fill DEPTH entries, then push again → overflow=1, path_len=256.
- Record 2 moves, then solve_fail → path_len=0; run gives no out_valid. clear then returns to RECORD with flags 0.
- Drop rst mid-REPLAY → out_valid=0 immediately, state RECORD.
- With PATH_COORD_EN, path 1,2,2,3 → (x,y) = (1,0), (1,1), (1,2), (0,2).

Source files
------------

// File: rtl/path_recorder.sv
// Direction-stack recorder for the maze solver: push/pop while searching, replay the path on request.
// Optional PATH_COORD_EN adds pos_x/pos_y giving the cell reached after each replayed move.
module path_recorder #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    dir_in,
    input  logic          solve_done,
    input  logic          solve_fail,
    input  logic          run,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [1:0]    dir_out,
    output logic          last,
    output logic [AW:0]   path_len,
    output logic          busy,
    output logic          overflow,
    output logic          underflow
`ifdef PATH_COORD_EN
    ,
    output logic [3:0]    pos_x,
    output logic [3:0]    pos_y
`endif
);

    typedef enum logic [1:0] {S_RECORD, S_READY, S_REPLAY, S_FAIL} state_t;

    localparam logic [AW:0]   SP_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   SP_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] RD_ONE   = AW'(1);

    state_t        state;
    logic [1:0]    mem [DEPTH];
    logic [AW:0]   sp;
    logic [AW:0]   sp_next;
    logic [AW:0]   sp_m1;
    logic [AW-1:0] rd;
    logic [AW-1:0] wr_addr;
    logic          do_write;
    logic          ovf_set;
    logic          unf_set;
    logic          is_empty;
    logic          is_full;
    logic          last_hit;

    assign sp_m1    = sp - SP_ONE;
    assign is_empty = (sp == '0);
    assign is_full  = (sp == SP_FULL);
    assign last_hit = ({1'b0, rd} == sp_m1);

    // push+pop together overwrites the top entry; on an empty stack it degrades to a plain push
    always_comb begin
        sp_next  = sp;
        do_write = 1'b0;
        wr_addr  = sp[AW-1:0];
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (push && pop && !is_empty) begin
            do_write = 1'b1;
            wr_addr  = sp_m1[AW-1:0];
        end else if (push) begin
            if (is_full) begin
                ovf_set = 1'b1;
            end else begin
                do_write = 1'b1;
                sp_next  = sp + SP_ONE;
            end
        end else if (pop) begin
            if (is_empty) unf_set = 1'b1;
            else          sp_next = sp_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (state == S_RECORD && !clear && do_write)
            mem[wr_addr] <= dir_in;
    end

    assign dir_out = out_valid ? mem[rd] : 2'd0;
    assign last    = out_valid & last_hit;

`ifdef PATH_COORD_EN
    logic [3:0] cur_x, cur_y, next_x, next_y;

    always_comb begin
        next_x = cur_x;
        next_y = cur_y;
        case (dir_out)
            2'd0:    next_y = cur_y - 4'd1;
            2'd1:    next_x = cur_x + 4'd1;
            2'd2:    next_y = cur_y + 4'd1;
            default: next_x = cur_x - 4'd1;
        endcase
    end

    assign pos_x = out_valid ? next_x : 4'd0;
    assign pos_y = out_valid ? next_y : 4'd0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_RECORD;
            sp        <= '0;
            rd        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            path_len  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef PATH_COORD_EN
            cur_x     <= 4'd0;
            cur_y     <= 4'd0;
`endif
        end else if (clear) begin
            state     <= S_RECORD;
            sp        <= '0;
            rd        <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            path_len  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
`ifdef PATH_COORD_EN
            cur_x     <= 4'd0;
            cur_y     <= 4'd0;
`endif
        end else begin
            case (state)
                S_RECORD: begin
                    overflow  <= overflow | ovf_set;
                    underflow <= underflow | unf_set;
                    if (solve_fail) begin
                        state    <= S_FAIL;
                        sp       <= '0;
                        path_len <= '0;
                    end else begin
                        sp       <= sp_next;
                        path_len <= sp_next;
                        if (solve_done) state <= S_READY;
                    end
                end
                S_READY: begin
                    if (run && !is_empty) begin
                        state     <= S_REPLAY;
                        rd        <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
`ifdef PATH_COORD_EN
                        cur_x     <= 4'd0;
                        cur_y     <= 4'd0;
`endif
                    end
                end
                S_REPLAY: begin
                    if (out_valid && out_ready) begin
`ifdef PATH_COORD_EN
                        cur_x <= next_x;
                        cur_y <= next_y;
`endif
                        if (last_hit) begin
                            state     <= S_READY;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            rd <= rd + RD_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_path_recorder.sv
// Randomized and directed bench for path_recorder against a queue-based stack model.
module tb_path_recorder;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clear = 1'b0, push = 1'b0, pop = 1'b0;
    logic [1:0] dir_in = 2'd0;
    logic solve_done = 1'b0, solve_fail = 1'b0, run = 1'b0, out_ready = 1'b0;
    logic out_valid, last, busy, overflow, underflow;
    logic [1:0] dir_out;
    logic [AW:0] path_len;
`ifdef PATH_COORD_EN
    logic [3:0] pos_x, pos_y;
`endif

    path_recorder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop),
        .dir_in(dir_in), .solve_done(solve_done), .solve_fail(solve_fail),
        .run(run), .out_valid(out_valid), .out_ready(out_ready),
        .dir_out(dir_out), .last(last), .path_len(path_len), .busy(busy),
        .overflow(overflow), .underflow(underflow)
`ifdef PATH_COORD_EN
        , .pos_x(pos_x), .pos_y(pos_y)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [1:0] stk[$];
    bit m_ovf = 0, m_unf = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one recording cycle; the model applies the stack rules then the DUT is compared
    task automatic step(input bit p, input bit q, input logic [1:0] d,
                        input bit done = 0, input bit fail = 0);
        push = p; pop = q; dir_in = d; solve_done = done; solve_fail = fail;
        tick();
        push = 0; pop = 0; solve_done = 0; solve_fail = 0;
        if (p && q && stk.size() > 0) stk[stk.size()-1] = d;
        else if (p) begin
            if (stk.size() == DEPTH) m_ovf = 1;
            else stk.push_back(d);
        end else if (q) begin
            if (stk.size() == 0) m_unf = 1;
            else void'(stk.pop_back());
        end
        if (fail) stk.delete();
        chk("path_len", path_len, stk.size());
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
    endtask

    task automatic do_clear();
        clear = 1;
        tick();
        clear = 0;
        stk.delete(); m_ovf = 0; m_unf = 0;
        chk("clr_path_len", path_len, 0);
        chk("clr_overflow", overflow, 0);
        chk("clr_underflow", underflow, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_busy", busy, 0);
    endtask

    task automatic rand_op(output bit p, output bit q);
        int r;
        r = $urandom_range(0, 9);
        p = (r < 6) || (r >= 8);
        q = (r >= 6);
    endtask

    // mode 0: always ready, 1: ready toggles 0,1,0,1..., 2: random ready
    task automatic replay(input int mode);
        int n, idx, cyc;
        bit rdy;
        logic [3:0] mx, my, ex, ey;
        n = stk.size(); idx = 0; cyc = 0; mx = 0; my = 0;
        chk("pre_run_valid", out_valid, 0);
        run = 1;
        tick();
        run = 0;
        while (idx < n && cyc < 4*n + 20) begin
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(cyc % 2) : bit'($urandom_range(0, 1));
            out_ready = rdy;
            chk("rp_valid", out_valid, 1);
            chk("rp_busy", busy, 1);
            chk("rp_dir", dir_out, stk[idx]);
            chk("rp_last", last, (idx == n-1));
            chk("rp_len", path_len, n);
            ex = mx + ((stk[idx] == 2'd1) ? 4'd1 : (stk[idx] == 2'd3) ? 4'd15 : 4'd0);
            ey = my + ((stk[idx] == 2'd2) ? 4'd1 : (stk[idx] == 2'd0) ? 4'd15 : 4'd0);
`ifdef PATH_COORD_EN
            chk("rp_pos_x", pos_x, ex);
            chk("rp_pos_y", pos_y, ey);
`endif
            if (out_valid && rdy) begin
                idx++; mx = ex; my = ey;
            end
            tick();
            cyc++;
        end
        out_ready = 0;
        chk("rp_handshakes", idx, n);
        chk("post_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_len", path_len, n);
    endtask

    initial begin
        bit p, q;
        int n;

        // reset state
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_dir", dir_out, 0);
        chk("rst_last", last, 0);
        chk("rst_len", path_len, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        rst = 1;
        tick();

        // basic path, replayed twice
        do_clear();
        step(1, 0, 2'd1); step(1, 0, 2'd1); step(1, 0, 2'd2); step(1, 0, 2'd3);
        step(0, 0, 2'd0, 1);
        replay(0);
        replay(0);

        // pop and replace-top
        do_clear();
        step(1, 0, 2'd1); step(1, 0, 2'd2); step(0, 1, 2'd0);
        step(1, 1, 2'd2); step(1, 0, 2'd1);
        step(0, 0, 2'd0, 1);
        chk("t2_len", path_len, 2);
        replay(0);

        // backpressure
        do_clear();
        for (int i = 0; i < 3; i++) step(1, 0, 2'($urandom_range(0, 3)));
        step(0, 0, 2'd0, 1);
        replay(1);

        // underflow, then run on an empty stack
        do_clear();
        step(0, 1, 2'd0);
        step(1, 1, 2'd3);
        step(0, 0, 2'd0, 1);
        replay(0);
        do_clear();
        step(0, 0, 2'd0, 1);
        run = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("empty_run_valid", out_valid, 0);
            chk("empty_run_busy", busy, 0);
        end
        run = 0;

        // fill to DEPTH, overflow
        do_clear();
        for (int i = 0; i < DEPTH; i++) step(1, 0, 2'($urandom_range(0, 3)));
        step(1, 0, 2'd2);
        chk("full_len", path_len, DEPTH);
        step(0, 0, 2'd0, 1);
        replay(2);

        // solve_fail
        do_clear();
        step(1, 0, 2'd2); step(1, 0, 2'd0);
        step(0, 0, 2'd0, 1, 1);
        run = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fail_valid", out_valid, 0);
            chk("fail_len", path_len, 0);
        end
        run = 0;
        do_clear();
        step(1, 0, 2'd1);

        // randomized recording sessions
        for (int r = 0; r < 5; r++) begin
            do_clear();
            n = $urandom_range(5, 60);
            for (int i = 0; i < n; i++) begin
                rand_op(p, q);
                step(p, q, 2'($urandom_range(0, 3)));
            end
            rand_op(p, q);
            step(p, q, 2'($urandom_range(0, 3)), 1);
            if (stk.size() > 0) replay(2);
        end

        // asynchronous reset during replay
        do_clear();
        for (int i = 0; i < 5; i++) step(1, 0, 2'($urandom_range(0, 3)));
        step(0, 0, 2'd0, 1);
        run = 1;
        tick();
        run = 0;
        tick();
        chk("pre_rst_valid", out_valid, 1);
        #2 rst = 0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_len", path_len, 0);
        chk("mid_rst_last", last, 0);
        rst = 1;
        stk.delete(); m_ovf = 0; m_unf = 0;
        step(1, 0, 2'd3);

        // coordinate path
        do_clear();
        step(1, 0, 2'd1); step(1, 0, 2'd2); step(1, 0, 2'd2); step(1, 0, 2'd3);
        step(0, 0, 2'd0, 1);
        replay(0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
